// File: rtl/logic_result_packer.sv
// logic_result_packer: packs LANES result beats (plus their op bits) into one
// wide word on a valid/ready output; flush emits a partial word early.
//  clk, rst_n           : clock, async active-low reset
//  in_valid/in_ready    : beat handshake; in_result data, in_op select bit
//  flush                : emit partially filled word (FILL only)
//  out_valid/out_ready  : word handshake
//  out_data/out_mask    : packed lanes (lane 0 in LSBs) and per-lane op bits
//  out_count            : number of valid lanes
//  out_csum             : XOR of all lanes (only when LRC_CSUM_EN is defined)
module logic_result_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_op,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*LANES-1:0]    out_data,
  output logic [LANES-1:0]           out_mask,
`ifdef LRC_CSUM_EN
  output logic [DATA_W-1:0]          out_csum,
`endif
  output logic [$clog2(LANES+1)-1:0] out_count
);

  localparam int CW = $clog2(LANES+1);
  localparam int IW = $clog2(LANES);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                       r_state, w_state_nxt;
  logic [CW-1:0]                r_cnt, w_cnt_nxt;
  logic [CW-1:0]                r_count, w_count_nxt;
  logic [CW-1:0]                w_filled;
  logic [LANES-1:0][DATA_W-1:0] r_data, w_data_nxt;
  logic [LANES-1:0]             r_mask, w_mask_nxt;
  logic                         w_fill, w_hold;
  logic                         w_acc, w_take;
  logic [IW-1:0]                w_idx;

  assign w_fill   = (r_state == FILL);
  assign w_hold   = (r_state == HOLD);
  assign in_ready = w_fill ? 1'b1 : out_ready;
  assign w_acc    = in_valid & in_ready;
  assign w_take   = w_hold & out_ready;
  assign w_idx    = r_cnt[IW-1:0];
  // lanes filled once this cycle's beat (if any) is counted
  assign w_filled = r_cnt + {{(CW-1){1'b0}}, w_acc};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    unique case (1'b1)
      w_fill: begin
        if (w_acc) begin
          w_data_nxt[w_idx] = in_result;
          w_mask_nxt[w_idx] = in_op;
        end
        w_cnt_nxt = w_filled;
        if ((w_acc && r_cnt == CW'(LANES-1)) ||
            (flush && w_filled != '0)) begin
          w_state_nxt = HOLD;
          w_count_nxt = w_filled;
          w_cnt_nxt   = '0;
        end
      end
      w_hold: begin
        if (w_take) begin
          w_state_nxt = FILL;
          w_data_nxt  = '0;
          w_mask_nxt  = '0;
          w_count_nxt = '0;
          w_cnt_nxt   = '0;
          // beat arriving with the take starts the next word, no bubble
          if (w_acc) begin
            w_data_nxt[0] = in_result;
            w_mask_nxt[0] = in_op;
            w_cnt_nxt     = CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign out_valid = w_hold;
  assign out_data  = r_data;
  assign out_mask  = r_mask;
  assign out_count = r_count;

`ifdef LRC_CSUM_EN
  logic [DATA_W-1:0] r_csum, w_csum_nxt;

  // cleared lanes are zero, so they drop out of the XOR
  always_comb begin
    w_csum_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_csum_nxt = w_csum_nxt ^ w_data_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_csum <= '0;
    else        r_csum <= w_csum_nxt;
  end

  assign out_csum = r_csum;
`endif

endmodule

// File: tb/tb_logic_result_packer.sv
// tb_logic_result_packer: directed + random stimulus for logic_result_packer,
// checked against a queue-based word model.
module tb_logic_result_packer;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int DW     = DATA_W * LANES;
  localparam int CW     = $clog2(LANES+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_op, flush;
  logic [DATA_W-1:0] in_result;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic [LANES-1:0]  out_mask;
  logic [CW-1:0]     out_count;
`ifdef LRC_CSUM_EN
  logic [DATA_W-1:0] out_csum;
`endif

  logic_result_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask),
`ifdef LRC_CSUM_EN
    .out_csum(out_csum),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0]     d;
    logic [LANES-1:0]  m;
    int                c;
    logic [DATA_W-1:0] x;
  } word_t;

  logic [DATA_W-1:0] pend_d[$];
  logic              pend_o[$];
  word_t             exp_q[$];

  function automatic word_t mk_word();
    word_t w;
    w.d = '0; w.m = '0; w.x = '0;
    w.c = pend_d.size();
    for (int i = 0; i < pend_d.size(); i++) begin
      w.d[i*DATA_W +: DATA_W] = pend_d[i];
      w.m[i] = pend_o[i];
      w.x = w.x ^ pend_d[i];
    end
    pend_d.delete();
    pend_o.delete();
    return w;
  endfunction

  // Model: a word exists (held) whenever exp_q is non-empty.
  bit    m_hold;
  word_t m_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_d.delete();
      pend_o.delete();
      exp_q.delete();
    end else begin
      m_hold = (exp_q.size() != 0);
      chk("out_valid", out_valid, m_hold);
      chk("in_ready", in_ready, m_hold ? out_ready : 1'b1);
      if (m_hold) begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_mask", out_mask, exp_q[0].m);
        chk("out_count", out_count, exp_q[0].c);
`ifdef LRC_CSUM_EN
        chk("out_csum", out_csum, exp_q[0].x);
`endif
        if (out_ready) begin
          m_w = exp_q.pop_front();
          if (in_valid) begin
            pend_d.push_back(in_result);
            pend_o.push_back(in_op);
          end
        end
      end else begin
        if (in_valid) begin
          pend_d.push_back(in_result);
          pend_o.push_back(in_op);
        end
        if (pend_d.size() == LANES ||
            (flush && pend_d.size() >= 1))
          exp_q.push_back(mk_word());
      end
    end
  end

  task automatic beat(input logic [DATA_W-1:0] d, input logic op);
    bit ok = 0;
    in_valid  = 1'b1;
    in_result = d;
    in_op     = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("beat_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  logic [DW-1:0]    wd;
  logic [LANES-1:0] wm;
  logic [DATA_W-1:0] b;
  logic              o;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_op = 0; flush = 0;
    in_result = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // basic word
    out_ready = 1'b1;
    beat(8'h11, 1); beat(8'h22, 0); beat(8'h33, 1);
    chk("t1_not_yet", out_valid, 0);
    beat(8'h44, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h44332211);
    chk("t1_mask", out_mask, 4'b1101);
    chk("t1_count", out_count, 4);
    wait_idle();

    // streaming 12 beats
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      in_result = DATA_W'($urandom);
      in_op     = 1'($urandom);
      @(negedge clk);
      chk("t2_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // flush partial word, then flush on empty packer
    out_ready = 1'b0;
    beat(8'hAA, 1'($urandom)); beat(8'hBB, 1'($urandom));
    pulse_flush();
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 32'h0000BBAA);
    chk("t3_count", out_count, 2);
    chk("t3_mask_hi", out_mask[3:2], 0);
    wait_idle();
    pulse_flush();
    chk("t3_empty_flush", out_valid, 0);
    @(posedge clk); #1;
    chk("t3_empty_flush2", out_valid, 0);

    // back-pressure
    out_ready = 1'b0;
    wd = '0; wm = '0;
    for (int i = 0; i < LANES; i++) begin
      b = DATA_W'($urandom); o = 1'($urandom);
      wd[i*DATA_W +: DATA_W] = b; wm[i] = o;
      beat(b, o);
    end
    in_valid = 1'b1; in_result = 8'h55; in_op = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_hold_data", out_data, wd);
      chk("t4_hold_mask", out_mask, wm);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_hi", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_taken", out_valid, 0);
    pulse_flush();
    chk("t4_next_data", out_data, 32'h00000055);
    chk("t4_next_count", out_count, 1);
    chk("t4_next_mask", out_mask, 4'b0001);
    wait_idle();

    // async reset mid-word
    for (int i = 0; i < 3; i++) beat(DATA_W'($urandom) | 8'h01, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_mask", out_mask, 0);
    chk("t5_rst_count", out_count, 0);
    chk("t5_rst_valid", out_valid, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    beat(8'hA1, 0); beat(8'hA2, 1); beat(8'hA3, 0); beat(8'hA4, 0);
    chk("t5_clean_data", out_data, 32'hA4A3A2A1);
    chk("t5_clean_mask", out_mask, 4'b0010);
    wait_idle();

`ifdef LRC_CSUM_EN
    out_ready = 1'b0;
    beat(8'h0F, 1); beat(8'hF0, 1); beat(8'hFF, 0); beat(8'h01, 1);
    chk("t6_csum_full", out_csum, 8'h01);
    wait_idle();
    out_ready = 1'b0;
    beat(8'h12, 0); beat(8'h34, 1);
    pulse_flush();
    chk("t6_csum_flush", out_csum, 8'h26);
    wait_idle();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_result = DATA_W'($urandom);
      in_op     = 1'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0;
    wait_idle();
    pulse_flush();
    wait_idle();
    chk("end_words_left", exp_q.size(), 0);
    chk("end_beats_left", pend_d.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
